// File: rtl/pid_chan.sv
// rtl/pid_chan.sv - single-channel PID controller, three-stage sample pipeline with clamp and anti-windup
module pid_chan #(
  parameter int DW  = 14,
  parameter int KW  = 14,
  parameter int IW  = 32,
  parameter int PSR = 12,
  parameter int ISR = 18,
  parameter int DSR = 10
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic signed [DW-1:0] dat_i,
  input  logic                 vld_i,
  input  logic signed [DW-1:0] set_i,
  input  logic signed [KW-1:0] kp_i,
  input  logic signed [KW-1:0] ki_i,
  input  logic signed [KW-1:0] kd_i,
  input  logic signed [DW-1:0] lim_hi_i,
  input  logic signed [DW-1:0] lim_lo_i,
  input  logic                 irst_i,
  input  logic                 ihold_i,
  output logic signed [DW-1:0] dat_o,
  output logic                 vld_o,
  output logic                 sat_hi_o,
  output logic                 sat_lo_o,
  output logic signed [IW-1:0] int_o
);

  // Error, error-difference, product and sum widths
  localparam int EW  = DW + 1;
  localparam int DEW = DW + 2;
  localparam int PW  = KW + EW;
  localparam int DPW = KW + DEW;
  localparam int SW  = IW + 2;

  // Symmetric integrator limits +/-(2^(IW-1)-1), held one bit wider than the accumulator
  localparam logic signed [IW:0] ACC_MAX = {2'b00, {(IW-1){1'b1}}};
  localparam logic signed [IW:0] ACC_MIN = {2'b11, {(IW-2){1'b0}}, 1'b1};

  // ---------------- S1: error and error difference ----------------
  logic signed [EW-1:0]  e_d, e_q, eprev_q;
  logic signed [DEW-1:0] de_d, de_q;
  logic                  v1_q;

  // Error against setpoint and difference against the previous sample's error
  always_comb begin
    e_d  = EW'(set_i) - EW'(dat_i);
    de_d = DEW'(e_d) - DEW'(eprev_q);
  end

  // S1 registers; e_prev is cleared by irst_i on every cycle, sample or not
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      v1_q    <= 1'b0;
      e_q     <= '0;
      de_q    <= '0;
      eprev_q <= '0;
    end else begin
      v1_q <= vld_i;
      if (vld_i) begin
        e_q  <= e_d;
        de_q <= de_d;
      end
      if (irst_i) begin
        eprev_q <= '0;
      end else if (vld_i) begin
        eprev_q <= e_d;
      end
    end
  end

  // ---------------- S2: P, I, D terms and integrator ----------------
  logic signed [PW-1:0]  p_prod, kie;
  logic signed [DPW-1:0] d_prod;
  logic signed [IW:0]    acc_sum;
  logic signed [IW-1:0]  acc_sat, int_d, int_acc_q;
  logic signed [SW-1:0]  p_d, i_d, d_d, p_q, i_q, d_q;
  logic                  kie_pos, kie_neg, windup;
  logic                  v2_q;
  logic                  sat_hi_q, sat_lo_q;

  // Gain products, saturating accumulate and the anti-windup / hold / reset selection
  always_comb begin
    p_prod  = PW'(kp_i) * PW'(e_q);
    d_prod  = DPW'(kd_i) * DPW'(de_q);
    kie     = PW'(ki_i) * PW'(e_q);
    acc_sum = (IW+1)'(int_acc_q) + (IW+1)'(kie);

    if (acc_sum > ACC_MAX) begin
      acc_sat = ACC_MAX[IW-1:0];
    end else if (acc_sum < ACC_MIN) begin
      acc_sat = ACC_MIN[IW-1:0];
    end else begin
      acc_sat = acc_sum[IW-1:0];
    end

    // Only block accumulation that would push further into the active clamp
    kie_pos = !kie[PW-1] && (kie != '0);
    kie_neg = kie[PW-1];
    windup  = (sat_hi_q && kie_pos) || (sat_lo_q && kie_neg);

    int_d = int_acc_q;
    if (irst_i) begin
      int_d = '0;
    end else if (v1_q && !ihold_i && !windup) begin
      int_d = acc_sat;
    end

    // I is taken from the post-update accumulator of this very sample
    p_d = SW'(p_prod >>> PSR);
    d_d = SW'(d_prod >>> DSR);
    i_d = SW'(int_d >>> ISR);
  end

  // S2 registers; integrator follows int_d every cycle so irst_i acts without a sample
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      v2_q      <= 1'b0;
      p_q       <= '0;
      i_q       <= '0;
      d_q       <= '0;
      int_acc_q <= '0;
    end else begin
      v2_q      <= v1_q;
      int_acc_q <= int_d;
      if (v1_q) begin
        p_q <= p_d;
        i_q <= i_d;
        d_q <= d_d;
      end
    end
  end

  // ---------------- S3: sum and clamp ----------------
  logic signed [SW-1:0] sum, hi_ext, lo_ext;
  logic                 over, under;
  logic signed [DW-1:0] dat_d, dat_q;
  logic                 sat_hi_d, sat_lo_d;
  logic                 vld_q;

  // Clamp high first, then low, so inverted limits resolve to lim_lo on overflow
  always_comb begin
    sum    = p_q + i_q + d_q;
    hi_ext = SW'(lim_hi_i);
    lo_ext = SW'(lim_lo_i);
    over   = sum > hi_ext;
    under  = over ? (lim_lo_i > lim_hi_i) : (sum < lo_ext);

    dat_d = sum[DW-1:0];
    if (under) begin
      dat_d = lim_lo_i;
    end else if (over) begin
      dat_d = lim_hi_i;
    end
    sat_hi_d = over && !under;
    sat_lo_d = under;
  end

  // Output registers hold between samples; vld_o is a one-cycle pulse
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      vld_q    <= 1'b0;
      dat_q    <= '0;
      sat_hi_q <= 1'b0;
      sat_lo_q <= 1'b0;
    end else begin
      vld_q <= v2_q;
      if (v2_q) begin
        dat_q    <= dat_d;
        sat_hi_q <= sat_hi_d;
        sat_lo_q <= sat_lo_d;
      end
    end
  end

  assign dat_o    = dat_q;
  assign vld_o    = vld_q;
  assign sat_hi_o = sat_hi_q;
  assign sat_lo_o = sat_lo_q;
  assign int_o    = int_acc_q;

endmodule

// File: tb/tb_pid_chan.sv
// tb/tb_pid_chan.sv - directed-vector bench for pid_chan
module tb_pid_chan;

  localparam int DW = 14;
  localparam int KW = 14;
  localparam int IW = 32;

  logic                 clk_i = 1'b0;
  logic                 rstn_i;
  logic signed [DW-1:0] dat_i, set_i, lim_hi_i, lim_lo_i;
  logic                 vld_i, irst_i, ihold_i;
  logic signed [KW-1:0] kp_i, ki_i, kd_i;
  logic signed [DW-1:0] dat_o;
  logic                 vld_o, sat_hi_o, sat_lo_o;
  logic signed [IW-1:0] int_o;

  int n_vec = 0;
  int n_bad = 0;

  pid_chan dut (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .dat_i    (dat_i),
    .vld_i    (vld_i),
    .set_i    (set_i),
    .kp_i     (kp_i),
    .ki_i     (ki_i),
    .kd_i     (kd_i),
    .lim_hi_i (lim_hi_i),
    .lim_lo_i (lim_lo_i),
    .irst_i   (irst_i),
    .ihold_i  (ihold_i),
    .dat_o    (dat_o),
    .vld_o    (vld_o),
    .sat_hi_o (sat_hi_o),
    .sat_lo_o (sat_lo_o),
    .int_o    (int_o)
  );

  always #4 clk_i = ~clk_i;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic pulse_irst();
    irst_i = 1'b1;
    tick();
    irst_i = 1'b0;
  endtask

  // One sample in, wait (bounded) for its vld_o; lat counts negedges from drive
  task automatic send(input logic signed [DW-1:0] s, input logic signed [DW-1:0] d, output int lat);
    set_i = s;
    dat_i = d;
    vld_i = 1'b1;
    tick();
    vld_i = 1'b0;
    lat = 1;
    while (vld_o !== 1'b1 && lat < 8) begin
      tick();
      lat++;
    end
    if (vld_o !== 1'b1) chk("send_timeout", vld_o, 1);
  endtask

  int lat;
  int nv;

  initial begin
    rstn_i = 1'b0; vld_i = 1'b0; irst_i = 1'b0; ihold_i = 1'b0;
    dat_i = '0; set_i = '0; kp_i = '0; ki_i = '0; kd_i = '0;
    lim_hi_i = 14'sd8191; lim_lo_i = -14'sd8191;
    tick(3);
    chk("rst_dat", dat_o, 0);
    chk("rst_vld", vld_o, 0);
    chk("rst_sat_hi", sat_hi_o, 0);
    chk("rst_sat_lo", sat_lo_o, 0);
    chk("rst_int", int_o, 0);
    rstn_i = 1'b1;
    tick(2);

    // Proportional path
    kp_i = 14'sd4096;
    send(1000, 0, lat);
    chk("p_lat", lat, 3);
    chk("p_dat0", dat_o, 1000);
    send(1000, 1500, lat);
    chk("p_dat1", dat_o, -500);
    chk("p_sat_hi", sat_hi_o, 0);

    // Integrator ramp, samples gapped by the send task
    kp_i = '0; ki_i = 14'sd4096;
    pulse_irst();
    for (int k = 1; k <= 10; k++) begin
      send(64, 0, lat);
      chk($sformatf("ramp_dat%0d", k), dat_o, k);
    end
    chk("ramp_int", int_o, 2621440);
    nv = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (vld_o) nv++;
    end
    chk("gap_vld", nv, 0);
    chk("gap_int", int_o, 2621440);
    chk("gap_dat", dat_o, 10);

    // Integrator hold
    ihold_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      send(64, 0, lat);
      chk("hold_dat", dat_o, 10);
    end
    chk("hold_int", int_o, 2621440);
    ihold_i = 1'b0;

    // One-cycle integrator reset between samples
    pulse_irst();
    chk("irst_int", int_o, 0);
    kp_i = 14'sd4096; ki_i = '0;
    send(64, 0, lat);
    chk("irst_pd", dat_o, 64);
    chk("irst_int2", int_o, 0);

    // Reset wins over hold
    kp_i = '0; ki_i = 14'sd4096;
    send(64, 0, lat);
    chk("rh_pre", int_o, 262144);
    ihold_i = 1'b1;
    pulse_irst();
    chk("rh_int", int_o, 0);
    ihold_i = 1'b0;

    // Derivative, unity at DSR=10
    ki_i = '0; kd_i = 14'sd1024;
    pulse_irst();
    send(0, 0, lat);   chk("d0", dat_o, 0);
    send(0, 0, lat);   chk("d1", dat_o, 0);
    send(0, 100, lat); chk("d2", dat_o, -100);
    send(0, 100, lat); chk("d3", dat_o, 0);

    // Clamp and anti-windup: each sample adds 4096000, I = floor(k*15.625)
    kd_i = '0; ki_i = 14'sd4096; lim_hi_i = 14'sd500;
    pulse_irst();
    for (int k = 1; k <= 36; k++) begin
      send(1000, 0, lat);
      if (k == 32) begin
        chk("clamp32_dat", dat_o, 500);
        chk("clamp32_sat", sat_hi_o, 0);
      end
      if (k == 33) begin
        chk("clamp33_dat", dat_o, 500);
        chk("clamp33_sat", sat_hi_o, 1);
        chk("clamp33_int", int_o, 135168000);
      end
    end
    chk("aw_int", int_o, 135168000);
    chk("aw_dat", dat_o, 500);
    chk("aw_sat", sat_hi_o, 1);
    send(1000, 2000, lat);
    chk("unwind_int", int_o, 131072000);
    chk("unwind_sat", sat_hi_o, 0);
    chk("unwind_dat", dat_o, 500);
    send(1000, 2000, lat);
    chk("unwind2_dat", dat_o, 484);
    chk("unwind2_int", int_o, 126976000);

    // Low clamp and anti-windup on the negative side
    lim_lo_i = 14'sd490;
    send(1000, 2000, lat);
    chk("lo_dat", dat_o, 490);
    chk("lo_sat", sat_lo_o, 1);
    chk("lo_int", int_o, 122880000);
    send(1000, 2000, lat);
    chk("lo_aw_int", int_o, 122880000);

    // Async reset with samples in flight
    lim_hi_i = 14'sd8191; lim_lo_i = -14'sd8191;
    ki_i = '0; kd_i = 14'sd1024;
    pulse_irst();
    nv = 0;
    set_i = 100; dat_i = 0; vld_i = 1'b1;
    tick();
    if (vld_o) nv++;
    dat_i = 50;
    tick();
    if (vld_o) nv++;
    dat_i = 20;
    rstn_i = 1'b0;
    #1;
    chk("arst_dat", dat_o, 0);
    chk("arst_vld", vld_o, 0);
    chk("arst_sat_lo", sat_lo_o, 0);
    chk("arst_sat_hi", sat_hi_o, 0);
    chk("arst_int", int_o, 0);
    vld_i = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k == 1) rstn_i = 1'b1;
      if (vld_o) nv++;
    end
    chk("arst_stray", nv, 0);
    send(100, 0, lat);
    chk("arst_first", dat_o, 100);
    chk("arst_lat", lat, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pid_chan.md
# pid_chan

Parametrised single-channel PID controller and next-generation replacement for the fixed-width PID section in the ADC→DAC feedback path.

- Widths, gain scaling and integrator depth are parameters.
- New over the previous section: sample-valid handshake, programmable output clamp with anti-windup, integrator hold, and saturation flags.
- The register bank drives all configuration inputs. One instance is used per MIMO matrix element.

## Interface
- DW, 14: ADC/DAC sample width, two's complement.
- KW, 14: gain width (kp, ki, kd), signed.
- IW, 32: integrator accumulator width, signed.
- PSR, 12: right shift applied to the proportional product.
- ISR, 18: right shift applied to the integrator value.
- DSR, 10: right shift applied to the derivative product.

- clk_i  in  1  system clock, 125 MHz.
- rstn_i  in  1  asynchronous active-low reset.
- dat_i  in  DW  measured input sample, signed.
- vld_i  in  1  dat_i valid strobe, one sample per high cycle.
- set_i  in  DW  setpoint, signed.
- kp_i / ki_i / kd_i  in  KW each  gains, signed.
- lim_hi_i / lim_lo_i  in  DW each  output clamp limits, signed.
- irst_i  in  1  integrator reset, level.
- ihold_i  in  1  integrator hold, level.
- dat_o  out  DW  controller output, signed, registered.
- vld_o  out  1  dat_o updated strobe.
- sat_hi_o / sat_lo_o  out  1 each  dat_o clamped at the high / low limit.
- int_o  out  IW  integrator accumulator, for readback.

## Operation
The block is a three-stage pipeline. It advances only on vld_i; no internal state changes on cycles where vld_i=0 (irst_i excepted).

- **S1:** e = set_i − dat_i, computed in DW+1 bits. Register e and latch de = e − e_prev. Then e_prev ← e.
- **S2:**
  - P = (kp·e) >>> PSR.
  - D = (kd·de) >>> DSR.
  - Integrator: int_acc ← sat_IW(int_acc + ki·e). Saturation is symmetric at ±(2^(IW−1)−1).
  - I = int_acc >>> ISR. I uses the updated int_acc.
  - All shifts are arithmetic (floor).
- **S3:**
  - sum = P + I + D, computed in IW+2 bits.
  - dat_o = lim_hi if sum > lim_hi, else lim_lo if sum < lim_lo, else sum.
  - If lim_lo > lim_hi, the result is lim_lo whenever sum > lim_hi.
  - sat_hi_o / sat_lo_o indicate which clamp was applied.
- **Anti-windup:** the integrator update is skipped when the current sat_hi_o=1 and ki·e > 0, or when sat_lo_o=1 and ki·e < 0.
- **ihold_i=1:** the integrator is not updated. P and D stay live, and I uses the held value.
- **irst_i=1:** int_acc and e_prev are set to 0 every cycle, regardless of vld_i. irst_i has priority over ihold_i and over accumulation.
- Gains and limits are sampled when used. Changing them mid-stream is legal and takes effect on the next sample entering the relevant stage.

## Timing
- Latency: vld_i high at cycle n gives vld_o high at n+3, with dat_o valid in that same cycle. vld_o is a single-cycle pulse per input sample.
- Throughput: one sample per clock; back-to-back vld_i is supported.
- Reset values: dat_o, vld_o, sat_hi_o, sat_lo_o and int_o are 0. Internal pipeline, e_prev and int_acc are also 0. Valid bits in flight are cleared.
- Reset asserted mid-stream: in-flight samples are dropped and no vld_o is produced for them. The first sample after release behaves as if e_prev = 0.
- dat_o, sat_hi_o and sat_lo_o hold their last value between vld_o pulses.
- int_o reflects int_acc one cycle after each update.

## Test plan
- **Proportional path.** Settings: kp=4096 (unity at PSR=12), ki=kd=0, lim ±8191, set=1000. Drive dat=0 with vld_i at cycle 0.
  - Required: vld_o at cycle 3 with dat_o=1000.
  - Then drive dat=1500: dat_o=−500.
- **Integrator ramp.** Settings: kp=kd=0, ki=4096, e=64, so each sample adds 2^18. Drive 10 consecutive valids.
  - Required: dat_o = 1, 2, …, 10 and int_o = 10·2^18.
  - With vld_i gapped: no change during the gaps.
- **Clamp and anti-windup.** Settings: lim_hi=500, ki=4096, e=1000.
  - Required: dat_o saturates at 500 with sat_hi_o=1, and int_o stops increasing.
  - Then drive e negative: int_acc decreases immediately and dat_o leaves the clamp with no windup delay.
- **Derivative.** Settings: kd=1024 (unity), kp=ki=0, set=0. Drive dat: 0, 0, 100, 100.
  - Required: dat_o = 0, 0, −100, 0.
- **Hold and reset.**
  - ihold_i=1 during the integrator ramp: dat_o stays constant.
  - irst_i pulsed for 1 cycle between valids: int_o reads 0 on the next cycle, and the next output = P + D only.
  - irst_i=1 together with ihold_i=1: int_acc is cleared.
- **Async reset mid-stream.** Assert rstn_i low for 2 cycles with 3 samples in flight.
  - Required: all outputs are 0 immediately and no stray vld_o appears.
  - After release, the first sample with dat=0 and set=100 under unity derivative gives dat_o=100.
